sleep_issuer: RTL
=================

SLEEP_ISSUER -- requirements
Module: sleep_issuer

Interface
REQ-001 SHALL have parameter CNT_W, default 21, width of the internal sleep-cycle counter.
REQ-002 SHALL have port sclk  in  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  in  1  decode presents a sleep/halt command.
REQ-005 SHALL have port cmd_op  in  1  0 = timed sleep, 1 = halt until irq.
REQ-006 SHALL have port cmd_value  in  16  sleep length, or halt timeout.
REQ-007 SHALL have port cmd_div  in  5  prescale; each value unit lasts cmd_div+1 cycles.
REQ-008 SHALL have port irq  in  1  external wake event; level-sampled.
REQ-009 SHALL have port cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-010 SHALL have port sleep  out  1  load strobe to the clock gater.
REQ-011 SHALL have port value  out  16  latched cmd_value toward the gater.
REQ-012 SHALL have port divider  out  5  latched cmd_div toward the gater.
REQ-013 SHALL have port wake  out  1  CPU run enable; 0 freezes the gated clock.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-015 SHALL have port done  out  1  one-cycle completion pulse.
REQ-016 SHALL have port timed_out  out  1  sticky halt-timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, ARM, SLEEP, HALT, DONE.
REQ-018 SHALL drive cmd_ready=1 only in IDLE; cmd_valid in any other state is ignored.
REQ-019 SHALL, in IDLE on an accepted cmd_op=0, latch value/divider and enter ARM.
REQ-020 SHALL assert sleep=1 for exactly the one ARM cycle, then enter SLEEP.
REQ-021 SHALL, on entering SLEEP, load the counter with value*(divider+1)+1, computed at CNT_W bits without truncation (maximum 65535*32+1).
REQ-022 SHALL decrement the counter once per cycle in SLEEP and enter DONE in the cycle after the counter reads 1.
REQ-023 SHALL treat value=0 as a legal one-cycle sleep (ARM, 1 SLEEP cycle, DONE).
REQ-024 SHALL, in IDLE on an accepted cmd_op=1, latch value/divider, drive wake=0, and enter HALT.
REQ-025 SHALL keep wake=0 throughout HALT and return wake=1 in the DONE cycle.
REQ-026 SHALL leave HALT for DONE on the first cycle irq=1 is sampled in HALT; irq in the acceptance cycle is not seen until the next cycle.
REQ-027 SHALL ignore irq in IDLE, ARM, SLEEP and DONE.
REQ-028 SHALL assert done=1 for exactly the DONE cycle, then return to IDLE.
REQ-029 SHALL hold wake=1 in IDLE, ARM, SLEEP and DONE.
REQ-030 SHALL clear timed_out only on reset or on acceptance of a new command.

Reset
REQ-031 SHALL, with reset=0 at any time (including mid-SLEEP or mid-HALT), force: state=IDLE, sleep=0, value=0, divider=0, counter=0, wake=1, busy=0, done=0, timed_out=0, cmd_ready=1.
REQ-032 SHALL resume normal operation on the first rising sclk edge after reset deasserts.

Configuration
REQ-033 SHALL gate a halt timeout behind macro SLEEP_ISSUER_HALT_TIMEOUT_EN.
REQ-034 SHALL, with the macro defined and a latched value nonzero, load the counter on HALT entry with value*(divider+1), and on expiry go to DONE with timed_out set.
REQ-035 SHALL, with the macro defined, let irq win when irq and expiry coincide: go to DONE and do not set timed_out.
REQ-036 SHALL, with the macro defined, treat a latched value of 0 in HALT as no timeout.
REQ-037 SHALL, without the macro, hold HALT until irq or reset only, and tie timed_out to 0.

Verification
REQ-038 SHALL cover timed sleep: cmd_op=0, value=3, div=1 -> sleep high 1 cycle, SLEEP lasts 7 cycles, done pulse, wake stays 1.
REQ-039 SHALL cover the zero case: value=0, div=31 -> ARM, 1 SLEEP cycle, done on the 3rd cycle after acceptance.
REQ-040 SHALL cover halt: cmd_op=1, irq raised 10 cycles later -> wake=0 for 10 cycles, done next cycle, wake=1.
REQ-041 SHALL cover a busy command: cmd_valid during SLEEP -> cmd_ready=0, no latch change, command not executed.
REQ-042 SHALL cover timeout with the macro defined: cmd_op=1, value=4, div=0, no irq -> DONE after 4 HALT cycles, timed_out=1 until the next command.
REQ-043 SHALL cover reset mid-HALT: reset low -> wake=1, busy=0, all outputs at reset values immediately.

Source files
------------

// File: rtl/sleep_issuer.sv
// Sleep/halt command issuer: drives a clock gater for timed sleeps and holds the CPU halted until irq.
// Optional halt timeout enabled by defining SLEEP_ISSUER_HALT_TIMEOUT_EN.
module sleep_issuer #(
  parameter int unsigned CNT_W = 21
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic        cmd_op,
  input  logic [15:0] cmd_value,
  input  logic [4:0]  cmd_div,
  input  logic        irq,
  output logic        cmd_ready,
  output logic        sleep,
  output logic [15:0] value,
  output logic [4:0]  divider,
  output logic        wake,
  output logic        busy,
  output logic        done,
  output logic        timed_out
);

  typedef enum logic [2:0] {IDLE, ARM, SLEEP, HALT, DONE} state_e;

  state_e             state_q, state_d;
  logic [15:0]        value_q, value_d;
  logic [4:0]         divider_q, divider_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               sleep_q, sleep_d;
  logic               wake_q, wake_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [15:0]        mul_a;
  logic [4:0]         mul_b;
  logic [CNT_W-1:0]   prod;
`ifdef SLEEP_ISSUER_HALT_TIMEOUT_EN
  logic               to_q, to_d;
`endif

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    divider_d = divider_q;
    cnt_d     = cnt_q;
`ifdef SLEEP_ISSUER_HALT_TIMEOUT_EN
    to_d      = to_q;
`endif
    // One shared multiplier: halt entry uses the incoming command, sleep entry the latched one.
    mul_a = (state_q == IDLE) ? cmd_value : value_q;
    mul_b = (state_q == IDLE) ? cmd_div   : divider_q;
    prod  = CNT_W'(mul_a) * (CNT_W'(mul_b) + CNT_W'(1));
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          value_d   = cmd_value;
          divider_d = cmd_div;
`ifdef SLEEP_ISSUER_HALT_TIMEOUT_EN
          to_d      = 1'b0;
          if (cmd_op) cnt_d = prod;
`endif
          state_d   = cmd_op ? HALT : ARM;
        end
      end
      ARM: begin
        cnt_d   = prod + CNT_W'(1);
        state_d = SLEEP;
      end
      SLEEP: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      HALT: begin
        if (irq) begin
          state_d = DONE;
        end
`ifdef SLEEP_ISSUER_HALT_TIMEOUT_EN
        else if (value_q != 16'd0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
            to_d    = 1'b1;
          end
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    sleep_d     = (state_d == ARM);
    wake_d      = (state_d != HALT);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      value_q     <= '0;
      divider_q   <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      sleep_q     <= 1'b0;
      wake_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SLEEP_ISSUER_HALT_TIMEOUT_EN
      to_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      divider_q   <= divider_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      sleep_q     <= sleep_d;
      wake_q      <= wake_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SLEEP_ISSUER_HALT_TIMEOUT_EN
      to_q        <= to_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign sleep     = sleep_q;
  assign value     = value_q;
  assign divider   = divider_q;
  assign wake      = wake_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef SLEEP_ISSUER_HALT_TIMEOUT_EN
  assign timed_out = to_q;
`else
  assign timed_out = 1'b0;
`endif

endmodule
